// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage MIPS pipeline: forwarding selects, stall/flush
// generation, and a HI/LO busy counter. A shadow E/M/W destination pipeline means only decode fields are needed.
module hazard_unit #(
    parameter int unsigned REG_BITS   = 5,
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_BITS-1:0] rs_d,
    input  logic [REG_BITS-1:0] rt_d,
    input  logic [REG_BITS-1:0] write_reg_d,
    input  logic                reg_write_d,
    input  logic                mem_to_reg_d,
    input  logic                branch_d,
    input  logic                md_start_d,
    input  logic                mf_hilo_d,
    output logic [1:0]          forward_a_e,
    output logic [1:0]          forward_b_e,
    output logic                forward_a_d,
    output logic                forward_b_d,
    output logic                stall_f,
    output logic                stall_d,
    output logic                flush_e
);

    localparam int unsigned CNT_W = $clog2(MD_LATENCY + 1);

    logic [REG_BITS-1:0] rs_e_q, rt_e_q;
    logic [REG_BITS-1:0] write_reg_e_q, write_reg_m_q, write_reg_w_q;
    logic                reg_write_e_q, reg_write_m_q, reg_write_w_q;
    logic                mem_to_reg_e_q, mem_to_reg_m_q;
    logic [CNT_W-1:0]    md_cnt_q, md_cnt_d;

    logic       lw_stall, br_stall, md_stall, stall, busy;
    logic       e_rs, e_rt, m_rs, m_rt;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic match(input logic rw, input logic [REG_BITS-1:0] wr,
                                   input logic [REG_BITS-1:0] r);
        return rw && (wr != '0) && (wr == r);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] r,
                                           input logic rw_m, input logic [REG_BITS-1:0] wr_m,
                                           input logic rw_w, input logic [REG_BITS-1:0] wr_w);
        if (match(rw_m, wr_m, r))      return 2'b10;
        else if (match(rw_w, wr_w, r)) return 2'b01;
        else                           return 2'b00;
    endfunction

    always_comb begin
        busy     = (md_cnt_q != '0);
        e_rs     = match(reg_write_e_q, write_reg_e_q, rs_d);
        e_rt     = match(reg_write_e_q, write_reg_e_q, rt_d);
        m_rs     = match(reg_write_m_q, write_reg_m_q, rs_d);
        m_rt     = match(reg_write_m_q, write_reg_m_q, rt_d);
        lw_stall = mem_to_reg_e_q && (e_rs || e_rt);
        br_stall = branch_d && (e_rs || e_rt || (mem_to_reg_m_q && (m_rs || m_rt)));
        md_stall = (md_start_d || mf_hilo_d) && busy;
        stall    = lw_stall || br_stall || md_stall;
        fwd_a    = fwd_sel(rs_e_q, reg_write_m_q, write_reg_m_q, reg_write_w_q, write_reg_w_q);
        fwd_b    = fwd_sel(rt_e_q, reg_write_m_q, write_reg_m_q, reg_write_w_q, write_reg_w_q);

        // A stalled md_start_d is not accepted, so it must not reload the counter.
        md_cnt_d = md_cnt_q;
        if (md_start_d && !stall)
            md_cnt_d = CNT_W'(MD_LATENCY);
        else if (busy)
            md_cnt_d = md_cnt_q - CNT_W'(1);
    end

    always_comb begin
        forward_a_e = rst_n ? fwd_a : 2'b00;
        forward_b_e = rst_n ? fwd_b : 2'b00;
        forward_a_d = rst_n && m_rs;
        forward_b_d = rst_n && m_rt;
        stall_f     = rst_n && stall;
        stall_d     = rst_n && stall;
        flush_e     = rst_n && stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_e_q         <= '0;
            rt_e_q         <= '0;
            write_reg_e_q  <= '0;
            reg_write_e_q  <= 1'b0;
            mem_to_reg_e_q <= 1'b0;
            write_reg_m_q  <= '0;
            reg_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            write_reg_w_q  <= '0;
            reg_write_w_q  <= 1'b0;
            md_cnt_q       <= '0;
        end else begin
            if (stall) begin
                rs_e_q         <= '0;
                rt_e_q         <= '0;
                write_reg_e_q  <= '0;
                reg_write_e_q  <= 1'b0;
                mem_to_reg_e_q <= 1'b0;
            end else begin
                rs_e_q         <= rs_d;
                rt_e_q         <= rt_d;
                write_reg_e_q  <= write_reg_d;
                reg_write_e_q  <= reg_write_d;
                mem_to_reg_e_q <= mem_to_reg_d;
            end
            write_reg_m_q  <= write_reg_e_q;
            reg_write_m_q  <= reg_write_e_q;
            mem_to_reg_m_q <= mem_to_reg_e_q;
            write_reg_w_q  <= write_reg_m_q;
            reg_write_w_q  <= reg_write_m_q;
            md_cnt_q       <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed cycle-by-cycle vectors for hazard_unit, plus a hand-written reset-during-stall sequence.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_d, rt_d, write_reg_d;
    logic       reg_write_d, mem_to_reg_d, branch_d, md_start_d, mf_hilo_d;
    logic [1:0] forward_a_e, forward_b_e;
    logic       forward_a_d, forward_b_d, stall_f, stall_d, flush_e;
    logic [8:0] outs;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4:0] rs, rt, wr;
        logic       rw, mtr, br, mds, mfh;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    hazard_unit #(.REG_BITS(5), .MD_LATENCY(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .write_reg_d  (write_reg_d),
        .reg_write_d  (reg_write_d),
        .mem_to_reg_d (mem_to_reg_d),
        .branch_d     (branch_d),
        .md_start_d   (md_start_d),
        .mf_hilo_d    (mf_hilo_d),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .forward_a_d  (forward_a_d),
        .forward_b_d  (forward_b_d),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_e      (flush_e)
    );

    always #5 clk = ~clk;

    assign outs = {forward_a_e, forward_b_e, forward_a_d, forward_b_d, stall_f, stall_d, flush_e};

    // One vector = one decode cycle: D inputs and the outputs expected within that cycle.
    task automatic v(input int rs, input int rt, input int wr, input bit rw, input bit mtr,
                     input bit br, input bit mds, input bit mfh,
                     input int fae, input int fbe, input bit fad, input bit fbd, input bit st);
        vec_t t;
        t.rs  = 5'(rs);
        t.rt  = 5'(rt);
        t.wr  = 5'(wr);
        t.rw  = rw;
        t.mtr = mtr;
        t.br  = br;
        t.mds = mds;
        t.mfh = mfh;
        t.exp = {2'(fae), 2'(fbe), fad, fbd, st, st, st};
        vecs.push_back(t);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) v(0,0,0, 0,0,0,0,0, 0,0,0,0,0);
    endtask

    task automatic drive(input int rs, input int rt, input int wr, input bit rw, input bit mtr,
                         input bit br, input bit mds, input bit mfh);
        rs_d         = 5'(rs);
        rt_d         = 5'(rt);
        write_reg_d  = 5'(wr);
        reg_write_d  = rw;
        mem_to_reg_d = mtr;
        branch_d     = br;
        md_start_d   = mds;
        mf_hilo_d    = mfh;
    endtask

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got fae=%b fbe=%b fad=%b fbd=%b sf=%b sd=%b fe=%b, expected fae=%b fbe=%b fad=%b fbd=%b sf=%b sd=%b fe=%b",
                     name, got[8:7], got[6:5], got[4], got[3], got[2], got[1], got[0],
                     exp[8:7], exp[6:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        // rs, rt, wr, rw, mtr, br, mds, mfh | fae, fbe, fad, fbd, stall
        v(1,2,3, 1,0,0,0,0, 0,0,0,0,0);   // add $3
        v(3,4,6, 1,0,0,0,0, 0,0,0,0,0);   // sub rs=$3
        v(3,0,0, 0,0,0,0,0, 2,0,1,0,0);   // sub in E, add in M
        v(0,0,0, 0,0,0,0,0, 1,0,0,0,0);   // reader of $3 in E, add in W
        idle(2);
        v(0,0,0, 1,1,0,0,0, 0,0,0,0,0);   // lw $0
        v(0,0,0, 0,0,1,0,0, 0,0,0,0,0);   // beq $0: never stalls on $0
        v(0,0,0, 0,0,1,0,0, 0,0,0,0,0);
        idle(1);
        v(1,0,5, 1,1,0,0,0, 0,0,0,0,0);   // lw $5
        v(6,5,8, 1,0,0,0,0, 0,0,0,0,1);   // load-use stall
        v(6,5,8, 1,0,0,0,0, 0,0,0,1,0);   // re-presented
        v(0,0,0, 0,0,0,0,0, 0,1,0,0,0);   // dependent in E gets W forward
        idle(2);
        v(1,0,7, 1,0,0,0,0, 0,0,0,0,0);   // addi $7
        v(7,0,7, 1,0,0,0,0, 0,0,0,0,0);   // add $7,$7
        v(7,7,0, 0,0,0,0,0, 2,0,1,1,0);
        v(0,0,0, 0,0,0,0,0, 2,2,0,0,0);   // M and W both $7: M wins
        idle(2);
        v(2,0,7, 1,1,0,0,0, 0,0,0,0,0);   // lw $7
        v(7,0,0, 0,0,1,0,0, 0,0,0,0,1);   // beq $7: stall 1
        v(7,0,0, 0,0,1,0,0, 0,0,1,0,1);   // stall 2 (load in M)
        v(7,0,0, 0,0,1,0,0, 0,0,0,0,0);   // resolves from register file
        idle(1);
        v(1,0,9, 1,0,0,0,0, 0,0,0,0,0);   // add $9
        v(0,9,0, 0,0,1,0,0, 0,0,0,0,1);   // beq rt=$9: one stall
        v(0,9,0, 0,0,1,0,0, 0,0,0,1,0);
        v(0,0,0, 0,0,0,0,0, 0,1,0,0,0);
        idle(1);
        v(1,2,0, 0,0,0,1,0, 0,0,0,0,0);   // mult accepted
        for (int k = 0; k < 4; k++) v(0,0,10, 1,0,0,0,1, 0,0,0,0,1);
        v(0,0,10, 1,0,0,0,1, 0,0,0,0,0);  // mfhi accepted at N+5
        idle(4);
        v(0,0,5, 1,1,0,0,0, 0,0,0,0,0);   // lw $5
        v(5,0,0, 0,0,0,1,0, 0,0,0,0,1);   // mult stalled by load-use: not accepted
        v(0,0,10, 1,0,0,0,1, 0,0,0,0,0);  // mfhi sees no busy
        idle(1);
        v(0,0,0, 0,0,0,1,0, 0,0,0,0,0);   // mult accepted
        v(0,0,5, 1,1,0,0,0, 0,0,0,0,0);   // lw $5
        v(5,0,10, 1,0,0,0,1, 0,0,0,0,1);  // combined load-use + busy
        v(5,0,10, 1,0,0,0,1, 0,0,1,0,1);
        v(5,0,10, 1,0,0,0,1, 0,0,0,0,1);
        v(5,0,10, 1,0,0,0,1, 0,0,0,0,0);  // counter drained during stall
        idle(2);

        rst_n = 1'b0;
        drive(3,5,0, 0,0,1,0,1);
        #1 check("reset_busy_inputs", outs, 9'b0);
        repeat (2) @(negedge clk);
        drive(0,0,0, 0,0,0,0,0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rs, vecs[i].rt, vecs[i].wr, vecs[i].rw, vecs[i].mtr,
                  vecs[i].br, vecs[i].mds, vecs[i].mfh);
            #1 check($sformatf("vec%0d", i), outs, vecs[i].exp);
        end

        @(negedge clk);
        drive(0,0,5, 1,1,0,0,0);
        #1 check("rst_lw", outs, 9'b0);
        @(negedge clk);
        drive(6,5,8, 1,0,0,0,0);
        #1 check("rst_pre_stall", outs, 9'b000000111);
        #1 rst_n = 1'b0;
        #1 check("rst_async_clear", outs, 9'b0);
        @(negedge clk);
        #1 check("rst_held", outs, 9'b0);
        rst_n = 1'b1;
        drive(0,0,0, 0,0,0,0,0);
        #1 check("rst_release_idle", outs, 9'b0);
        @(negedge clk);
        #1 check("rst_idle_next", outs, 9'b0);
        @(negedge clk);
        drive(6,5,8, 1,0,0,0,0);
        #1 check("rst_no_carryover", outs, 9'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS core. It generates the forwarding selects that the execute-stage operand muxes (`forward_a_e`, `forward_b_e`) and the decode-stage branch-compare muxes consume. It also generates the fetch/decode stall and execute flush controls. It keeps its own shadow pipeline of destination-register state (E, M, W) and a multiply/divide busy counter, so it is driven only by decode-stage fields.

## Interface
Parameters:
- `REG_BITS`, 5, register-number width
- `MD_LATENCY`, 4, HI/LO multiply/divide occupancy in cycles (≥1)

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `rs_d`, `rt_d`  in  REG_BITS  source registers of the decode-stage instruction
- `write_reg_d`  in  REG_BITS  destination register of the decode-stage instruction
- `reg_write_d`  in  1  decode-stage instruction writes the register file
- `mem_to_reg_d`  in  1  decode-stage instruction is a load
- `branch_d`  in  1  decode-stage instruction is a branch; it is resolved in decode
- `md_start_d`  in  1  decode-stage instruction is mult/multu/div/divu
- `mf_hilo_d`  in  1  decode-stage instruction is mfhi/mflo
- `forward_a_e`, `forward_b_e`  out  2  execute operand select: 00 register file, 01 `result_w`, 10 `alu_out_m`
- `forward_a_d`, `forward_b_d`  out  1  branch-compare select: 1 = `alu_out_m`
- `stall_f`, `stall_d`  out  1  hold PC and the F/D register
- `flush_e`  out  1  load a bubble into the D/E register

## Operation
- Shadow state per stage X ∈ {e, m, w}: `write_reg_x`, `reg_write_x`, `mem_to_reg_x`. Stage E also holds `rs_e` and `rt_e`.
- Each rising edge:
  - If `flush_e` = 1, E is loaded with a bubble (all fields 0). Otherwise E is loaded with the D inputs.
  - M is loaded from E and W from M, unconditionally.
- `match(x, r)` = `reg_write_x` & (`write_reg_x` ≠ 0) & (`write_reg_x` == r). Register 0 is never forwarded and never causes a stall.
- `forward_a_e`:
  - 10 if `match(m, rs_e)`
  - else 01 if `match(w, rs_e)`
  - else 00
  - M has priority over W when both match.
- `forward_b_e`: same rule as `forward_a_e`, using `rt_e`.
- `forward_a_d` = `match(m, rs_d)`. `forward_b_d` = `match(m, rt_d)`.
- `lw_stall` = `mem_to_reg_e` & (`match(e, rs_d)` | `match(e, rt_d)`).
- `br_stall` = `branch_d` & (`match(e, rs_d)` | `match(e, rt_d)` | (`mem_to_reg_m` & (`match(m, rs_d)` | `match(m, rt_d)`))).
- `md_stall` = (`md_start_d` | `mf_hilo_d`) & `busy`.
- `stall` = `lw_stall` | `br_stall` | `md_stall`. `stall_f` = `stall_d` = `flush_e` = `stall`.
- Busy counter `md_cnt`, width clog2(`MD_LATENCY`+1):
  - On `md_start_d` & !`stall`: load `MD_LATENCY`.
  - Else if ≠ 0: decrement.
  - `busy` = (`md_cnt` ≠ 0).
- A stalled `md_start_d` is not accepted; it does not load the counter.

## Timing
- Reset (`rst_n` low, asynchronous): all shadow state = 0 and `md_cnt` = 0. All outputs are forced to 0 while `rst_n` is low.
- Outputs are combinational from registered state plus the D inputs. Zero-cycle latency to the muxes in the same cycle.
- Load-use: one stall cycle. The dependent instruction re-presents in D, then sees `forward_*_e` = 01 in E.
- Branch after ALU op: one stall cycle. Branch after load: two stall cycles.
- `md_start_d` accepted in cycle N → `busy` in cycles N+1 … N+`MD_LATENCY`. A `mf_hilo_d`/`md_start_d` is accepted in cycle N+`MD_LATENCY`+1 at the earliest.
- Simultaneous load-use and busy stall: single combined stall; the counter keeps decrementing.
- `rst_n` deasserted mid-stall: next cycle restarts from the empty pipeline; no stall carries over.

## Test plan
- `add $3` (`write_reg_d`=3, `reg_write_d`=1), then `sub` with `rs_d`=3 → cycle 2: `forward_a_e`=10; next cycle `forward_a_e`=01; no stall.
- `lw $5`, then `rt_d`=5 → `stall_f`=`stall_d`=`flush_e`=1 for exactly one cycle, then `forward_b_e`=01.
- `write_reg_d`=0 with `reg_write_d`=1, followed by `rs_d`=0 → `forward_a_e`=00 and no stall in every cycle.
- Back-to-back writes to $7 (M and W both match `rs_e`=7) → `forward_a_e`=10. `beq` with `rs_d`=7 after `lw $7` → two stall cycles, then `forward_a_d`=0 (value reaches D from the W-stage result).
- `mult` accepted at cycle 0, `mfhi` presented at cycle 1 → stall cycles 1–4 with `MD_LATENCY`=4; `mfhi` accepted at cycle 5. `md_start_d` during a `lw_stall` does not load `md_cnt`.
- Assert `rst_n`=0 during a `lw_stall` → all outputs 0 immediately; after release with idle inputs, the outputs stay 0.
